instr_loader: RTL and testbench

- Writer side of the instruction bank: accepts a framed byte stream from a host and writes 12-bit instruction words into the instruction bank at sequential addresses.
- The processor is the reader of the same bank.
- The block holds the processor halted (cpu_hold) until a complete, checksum-valid program is loaded.
- It sits between the host byte link and the instruction bank write port.

---
 rtl/instr_loader_pkg.sv | 19 +
 rtl/instr_loader.sv | 149 ++++++++++++++
 tb/tb_instr_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction bank loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LO,
    HI,
    WR,
    CSUM,
    DONE,
    ERR
  } state_t;

  // A LEN byte of zero requests a full-depth load.
  localparam logic [7:0] LEN_FULL = 8'h00;
  localparam logic [7:0] HI_MASK  = 8'hF0;

endpackage

// File: rtl/instr_loader.sv
// Framed host byte stream -> instruction bank writer; holds the CPU until a checksum-valid load.
// Optional: LOADER_HI_CHECK_EN aborts the load on a non-zero high nibble in a high byte.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int INSTR_W = 12,
  parameter int DEPTH   = 128
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_adr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [7:0]         word_count
);

  state_t state, state_nxt;
  logic [7:0] n_words, n_words_nxt;
  logic [7:0] lo_byte, lo_byte_nxt;
  logic [7:0] acc, acc_nxt;
  logic               in_ready_nxt, wr_en_nxt, cpu_hold_nxt, done_nxt, err_nxt;
  logic [ADDR_W-1:0]  wr_adr_nxt;
  logic [INSTR_W-1:0] wr_data_nxt;
  logic [7:0]         word_count_nxt;
  logic accept, hi_bad;

  assign accept = in_valid && in_ready;

`ifdef LOADER_HI_CHECK_EN
  assign hi_bad = (in_data & HI_MASK) != '0;
`else
  assign hi_bad = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    n_words_nxt    = n_words;
    lo_byte_nxt    = lo_byte;
    acc_nxt        = acc;
    wr_en_nxt      = 1'b0;
    wr_adr_nxt     = wr_adr;
    wr_data_nxt    = wr_data;
    cpu_hold_nxt   = cpu_hold;
    done_nxt       = done;
    err_nxt        = err;
    word_count_nxt = word_count;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_nxt      = LEN;
          word_count_nxt = '0;
          wr_adr_nxt     = '0;
          acc_nxt        = '0;
          done_nxt       = 1'b0;
          err_nxt        = 1'b0;
          cpu_hold_nxt   = 1'b1;
        end
      end
      LEN: begin
        if (accept) begin
          n_words_nxt = (in_data == LEN_FULL) ? 8'(DEPTH) : in_data;
          state_nxt   = LO;
        end
      end
      LO: begin
        if (accept) begin
          lo_byte_nxt = in_data;
          acc_nxt     = acc ^ in_data;
          state_nxt   = HI;
        end
      end
      HI: begin
        if (accept) begin
          acc_nxt = acc ^ in_data;
          if (hi_bad) begin
            state_nxt    = ERR;
            err_nxt      = 1'b1;
            cpu_hold_nxt = 1'b1;
          end else begin
            wr_en_nxt      = 1'b1;
            wr_data_nxt    = INSTR_W'({in_data[3:0], lo_byte});
            word_count_nxt = word_count + 8'd1;
            state_nxt      = WR;
          end
        end
      end
      WR: begin
        // word_count already includes the word being written this cycle.
        wr_adr_nxt = wr_adr + 1'b1;
        state_nxt  = (word_count == n_words) ? CSUM : LO;
      end
      CSUM: begin
        if (accept) begin
          if (in_data == acc) begin
            state_nxt    = DONE;
            done_nxt     = 1'b1;
            cpu_hold_nxt = 1'b0;
          end else begin
            state_nxt    = ERR;
            err_nxt      = 1'b1;
            cpu_hold_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    in_ready_nxt = (state_nxt == LEN) || (state_nxt == LO) ||
                   (state_nxt == HI)  || (state_nxt == CSUM);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= IDLE;
      n_words    <= '0;
      lo_byte    <= '0;
      acc        <= '0;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_adr     <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_nxt;
      n_words    <= n_words_nxt;
      lo_byte    <= lo_byte_nxt;
      acc        <= acc_nxt;
      in_ready   <= in_ready_nxt;
      wr_en      <= wr_en_nxt;
      wr_adr     <= wr_adr_nxt;
      wr_data    <= wr_data_nxt;
      cpu_hold   <= cpu_hold_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      word_count <= word_count_nxt;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader; inputs driven and outputs sampled on negedge.
module tb_instr_loader;

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [6:0]  wr_adr;
  logic [11:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [7:0]  word_count;

  int checks = 0;
  int errors = 0;
  logic [6:0]  adr_log[$];
  logic [11:0] data_log[$];

  instr_loader #(.ADDR_W(7), .INSTR_W(12), .DEPTH(128)) dut (
    .clk1(clk1), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk1 = ~clk1;

  always @(negedge clk1) begin
    if (wr_en === 1'b1) begin
      adr_log.push_back(wr_adr);
      data_log.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk1) start = 1'b1;
    @(negedge clk1) start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    for (int g = 0; g < gap; g++) @(negedge clk1);
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk1);
        @(negedge clk1);
        ok = 1;
      end else begin
        @(negedge clk1);
      end
    end
    in_valid = 1'b0;
    chk("byte_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic clear_log();
    adr_log.delete();
    data_log.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk1);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_adr", 32'(wr_adr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);

    // N=2 good frame, with write latency checked right after the first HI byte
    clear_log();
    pulse_start();
    chk("len_in_ready", 32'(in_ready), 32'd1);
    send_byte(8'h02, 0);
    send_byte(8'h80, 0);
    send_byte(8'h07, 0);
    chk("lat_wr_en", 32'(wr_en), 32'd1);
    chk("lat_wr_adr", 32'(wr_adr), 32'd0);
    chk("lat_wr_data", 32'(wr_data), 32'h780);
    chk("lat_word_count", 32'(word_count), 32'd1);
    chk("lat_in_ready", 32'(in_ready), 32'd0);
    send_byte(8'h8B, 0);
    send_byte(8'h07, 0);
    chk("csum_wait_done", 32'(done), 32'd0);
    send_byte(8'h0B, 0);
    chk("ok_done", 32'(done), 32'd1);
    chk("ok_err", 32'(err), 32'd0);
    chk("ok_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("ok_word_count", 32'(word_count), 32'd2);
    chk("ok_nwrites", 32'(adr_log.size()), 32'd2);
    if (adr_log.size() == 2) begin
      chk("ok_adr0", 32'(adr_log[0]), 32'd0);
      chk("ok_dat0", 32'(data_log[0]), 32'h780);
      chk("ok_adr1", 32'(adr_log[1]), 32'd1);
      chk("ok_dat1", 32'(data_log[1]), 32'h78B);
    end

    // in_valid outside a frame is not consumed
    @(negedge clk1) in_valid = 1'b1;
    in_data = 8'h55;
    repeat (3) begin
      @(negedge clk1);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("idle_done_held", 32'(done), 32'd1);

    // Bad checksum, restarted directly from DONE
    clear_log();
    pulse_start();
    chk("restart_done_clr", 32'(done), 32'd0);
    chk("restart_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h02, 0);
    send_byte(8'h80, 0);
    send_byte(8'h07, 0);
    send_byte(8'h8B, 0);
    send_byte(8'h07, 0);
    send_byte(8'h0C, 0);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("bad_nwrites", 32'(adr_log.size()), 32'd2);
    if (adr_log.size() == 2) chk("bad_dat1", 32'(data_log[1]), 32'h78B);

    // Gapped in_valid plus a start pulse mid-frame that must be ignored
    clear_log();
    pulse_start();
    chk("err_clr_on_start", 32'(err), 32'd0);
    send_byte(8'h02, 1);
    send_byte(8'h80, 1);
    send_byte(8'h07, 1);
    send_byte(8'h8B, 1);
    pulse_start();
    send_byte(8'h07, 1);
    send_byte(8'h0B, 1);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_word_count", 32'(word_count), 32'd2);
    chk("gap_nwrites", 32'(adr_log.size()), 32'd2);
    if (adr_log.size() == 2) begin
      chk("gap_dat0", 32'(data_log[0]), 32'h780);
      chk("gap_adr1", 32'(adr_log[1]), 32'd1);
      chk("gap_dat1", 32'(data_log[1]), 32'h78B);
    end

    // LEN=0 encodes a full 128-word load
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("full_done", 32'(done), 32'd1);
    chk("full_word_count", 32'(word_count), 32'd128);
    chk("full_adr_wrap", 32'(wr_adr), 32'd0);
    chk("full_nwrites", 32'(adr_log.size()), 32'd128);
    if (adr_log.size() == 128) begin
      for (int i = 0; i < 128; i++) begin
        chk("full_adr", 32'(adr_log[i]), 32'(i));
        chk("full_dat", 32'(data_log[i]), 32'h000);
      end
    end

    // Reset mid-load, then a fresh load starts at address 0
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h11, 0);
    send_byte(8'h01, 0);
    rst = 1'b1;
    @(negedge clk1);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_word_count", 32'(word_count), 32'd0);
    chk("mid_rst_wr_adr", 32'(wr_adr), 32'd0);
    rst = 1'b0;
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h34, 0);
    send_byte(8'h02, 0);
    send_byte(8'h36, 0);
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_nwrites", 32'(adr_log.size()), 32'd1);
    if (adr_log.size() == 1) begin
      chk("post_rst_adr", 32'(adr_log[0]), 32'd0);
      chk("post_rst_dat", 32'(data_log[0]), 32'h234);
    end

    // High byte with a non-zero upper nibble
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h55, 0);
    send_byte(8'h17, 0);
`ifdef LOADER_HI_CHECK_EN
    chk("hichk_err", 32'(err), 32'd1);
    chk("hichk_wr_en", 32'(wr_en), 32'd0);
    @(negedge clk1);
    chk("hichk_nwrites", 32'(adr_log.size()), 32'd0);
    chk("hichk_hold", 32'(cpu_hold), 32'd1);
`else
    chk("hi_wr_en", 32'(wr_en), 32'd1);
    chk("hi_wr_data", 32'(wr_data), 32'h755);
    send_byte(8'h42, 0);
    chk("hi_done", 32'(done), 32'd1);
    chk("hi_err", 32'(err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
